present80_decrypt: RTL
======================

PRESENT80_DECRYPT -- requirements
Module: present80_decrypt

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by PRESENT-80 (64-bit block, 80-bit key, 31 rounds).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 key  input  80  cipher key K (bit 79 = MSB), sampled with start.
REQ-006 data_in  input  64  ciphertext, sampled with start.
REQ-007 data_out  output  64  recovered plaintext; valid from done until the next accepted start.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse marking data_out valid.

Function
REQ-010 The FSM SHALL have states IDLE, KEYEXP, WHITEN, ROUND and DONE.
REQ-011 IDLE: start=1 SHALL latch key and data_in, set cnt=1 and go to KEYEXP; otherwise stay in IDLE.
REQ-012 KEYEXP: each cycle SHALL apply the forward schedule (rotate left 61; forward S-box on [79:76]; XOR cnt into [19:15]) and then increment cnt; when cnt=31 is processed, go to WHITEN holding K32.
REQ-013 WHITEN: state SHALL become state XOR key[79:16], with cnt=31; go to ROUND.
REQ-014 ROUND: each cycle SHALL compute K_cnt = inverse update of the key register (XOR cnt into [19:15]; inverse S-box on [79:76]; rotate right 61).
REQ-015 In the same ROUND cycle, state SHALL become invS(invP(state)) XOR K_cnt[79:16]; the key register takes K_cnt and cnt decrements.
REQ-016 invP SHALL move bit j to position i where P(i)=16*i mod 63 for i<63 and P(63)=63; invS SHALL be applied to all 16 nibbles.
REQ-017 ROUND SHALL exit to DONE after the cnt=1 update.
REQ-018 DONE SHALL assert done for exactly one cycle, drive data_out=state and return to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the 64th cycle after the edge that accepts start (31 KEYEXP + 1 WHITEN + 31 ROUND + DONE).
REQ-020 start while busy=1 or in DONE SHALL be ignored, with no effect on the operation in progress.
REQ-021 A start in the IDLE cycle that directly follows DONE SHALL be accepted normally (back-to-back operation).
REQ-022 data_out SHALL hold its value through IDLE and SHALL update only in DONE.
REQ-023 The cnt counter SHALL be 5 bits and never leave 1..31 outside IDLE.

Reset
REQ-024 rst_n=0 SHALL force IDLE immediately and clear busy, done, data_out, state, key register and cnt to 0.
REQ-025 Reset during any state SHALL abort the operation; no done pulse follows reset release.
REQ-026 After rst_n rises, the first start SHALL be accepted on the first clock edge.

Structure
REQ-027 The shared package present_pkg SHALL hold NUM_ROUNDS=31, the block/key widths, the FSM state encoding and the permutation index function.
REQ-028 The inverse S-box SHALL be one sub-module, present_inv_sbox (4-bit combinational table, inverse of the existing forward S-box), instantiated 17 times.
REQ-029 Of the 17 instances, 16 SHALL serve the data path and 1 the key schedule; the forward key-schedule nibble SHALL reuse the existing sbox module.

Verification
REQ-030 key=0, data_in=5579C1387B228445 -> data_out=0000000000000000, with done exactly 64 cycles after start.
REQ-031 key=FFFFFFFFFFFFFFFFFFFF, data_in=E72C46C0F5945049 -> data_out=0000000000000000.
REQ-032 key=0, data_in=A112FFC72F68417B -> FFFFFFFFFFFFFFFF; key=all-ones, data_in=3333DCD3213210D2 -> FFFFFFFFFFFFFFFF.
REQ-033 Second start pulsed at cycle 10 of an operation -> ignored; result and timing of the first operation are unchanged.
REQ-034 rst_n pulsed low in ROUND -> busy=0 and data_out=0 at once; no done pulse; a new operation then completes correctly.
REQ-035 Back-to-back: start in the IDLE cycle after done -> second result correct; data_out holds the first result until the second DONE.

Source files
------------

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared widths, FSM encoding and bit permutation index for PRESENT-80
package present_pkg;

  localparam int NUM_ROUNDS = 31;
  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 80;
  localparam int CNT_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_WHITEN = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Encryption moves bit i to position perm_idx(i); bit 63 is a fixed point.
  function automatic logic [5:0] perm_idx(input logic [5:0] i);
    int t;
    if (i == 6'd63) begin
      t = 63;
    end else begin
      t = (16 * int'(i)) % 63;
    end
    return 6'(t);
  endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// rtl/present_inv_sbox.sv - PRESENT inverse 4-bit S-box
module present_inv_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inverse substitution table (undoes present_sbox)
  always_comb begin
    case (din)
      4'h0: dout = 4'h5;
      4'h1: dout = 4'hE;
      4'h2: dout = 4'hF;
      4'h3: dout = 4'h8;
      4'h4: dout = 4'hC;
      4'h5: dout = 4'h1;
      4'h6: dout = 4'h2;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'hB;
      4'h9: dout = 4'h4;
      4'hA: dout = 4'h6;
      4'hB: dout = 4'h3;
      4'hC: dout = 4'h0;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h9;
      default: dout = 4'hA;
    endcase
  end

endmodule

// File: rtl/present_sbox.sv
// rtl/present_sbox.sv - PRESENT forward 4-bit S-box
module present_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Forward substitution table
  always_comb begin
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      default: dout = 4'h2;
    endcase
  end

endmodule

// File: rtl/present80_decrypt.sv
// rtl/present80_decrypt.sv - iterative PRESENT-80 decryption, one round per cycle
module present80_decrypt
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(1);

  state_t             cur, nxt;
  logic [KEY_W-1:0]   key_q;
  logic [BLOCK_W-1:0] st_q;
  logic [CNT_W-1:0]   cnt;

  // Forward schedule step, used to walk the key register up to K32
  logic [KEY_W-1:0] kf_rot, kf;
  logic [3:0]       kf_sb;
  assign kf_rot = {key_q[18:0], key_q[79:19]};
  present_sbox u_key_sbox (.din(kf_rot[79:76]), .dout(kf_sb));
  assign kf = {kf_sb, kf_rot[75:20], kf_rot[19:15] ^ cnt, kf_rot[14:0]};

  // Inverse schedule step: undo counter XOR, undo S-box, rotate right by 61
  logic [KEY_W-1:0] kx, ki_pre, ki;
  logic [3:0]       ki_sb;
  assign kx = {key_q[79:20], key_q[19:15] ^ cnt, key_q[14:0]};
  present_inv_sbox u_key_inv_sbox (.din(kx[79:76]), .dout(ki_sb));
  assign ki_pre = {ki_sb, kx[75:0]};
  assign ki = {ki_pre[60:0], ki_pre[79:61]};

  // Inverse bit permutation: output bit i comes from input bit perm_idx(i)
  logic [BLOCK_W-1:0] pl, sl, rnd;
  always_comb begin
    pl = '0;
    for (int i = 0; i < BLOCK_W; i++) begin
      pl[i] = st_q[perm_idx(6'(i))];
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    present_inv_sbox u_inv_sbox (.din(pl[4*g +: 4]), .dout(sl[4*g +: 4]));
  end

  assign rnd = sl ^ ki[79:16];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= ST_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state and status outputs
  always_comb begin
    nxt  = cur;
    busy = 1'b0;
    done = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (start) nxt = ST_KEYEXP;
      end
      ST_KEYEXP: begin
        busy = 1'b1;
        if (cnt == CNT_MAX) nxt = ST_WHITEN;
      end
      ST_WHITEN: begin
        busy = 1'b1;
        nxt  = ST_ROUND;
      end
      ST_ROUND: begin
        busy = 1'b1;
        if (cnt == CNT_MIN) nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Datapath: key register, cipher state, round counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      st_q     <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      case (cur)
        ST_IDLE: begin
          if (start) begin
            key_q <= key;
            st_q  <= data_in;
            cnt   <= CNT_MIN;
          end
        end
        ST_KEYEXP: begin
          key_q <= kf;
          // Counter parks at 31 so WHITEN and the first ROUND see it
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end
        ST_WHITEN: begin
          st_q <= st_q ^ key_q[79:16];
          cnt  <= CNT_MAX;
        end
        ST_ROUND: begin
          st_q  <= rnd;
          key_q <= ki;
          if (cnt != CNT_MIN) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Result lands as DONE begins so it is valid alongside done
            data_out <= rnd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
